// File: rtl/divider_controller.sv
`timescale 1ns/1ps
// Sequential restoring divider controller that borrows a shared ALU for its
// per-bit subtract, producing one quotient bit per cycle over 32 cycles.
module divider_controller #(
    parameter logic [5:0] SUB_FUNCT = 6'b001010,
    parameter logic [5:0] NOP_FUNCT = 6'b000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [5:0]  alu_funct,
    input  logic [31:0] alu_result,
    input  logic        alu_carry,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 6;
    localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] rem, rem_nxt;
    logic [DW-1:0] quo, quo_nxt;
    logic [DW-1:0] dvs, dvs_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          zdly, zdly_nxt;
    logic [DW-1:0] quotient_nxt, remainder_nxt;
    logic          dbz_nxt;
    logic [DW-1:0] shifted;
    logic          sub_ok;

    // Partial remainder shifted left by one with the next dividend bit appended.
    assign shifted = {rem[DW-2:0], quo[DW-1]};
    // A set MSB means the 33-bit shifted value exceeds any divisor.
    assign sub_ok  = !alu_carry || rem[DW-1];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            cnt         <= '0;
            zdly        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_nxt;
            rem         <= rem_nxt;
            quo         <= quo_nxt;
            dvs         <= dvs_nxt;
            cnt         <= cnt_nxt;
            zdly        <= zdly_nxt;
            quotient    <= quotient_nxt;
            remainder   <= remainder_nxt;
            div_by_zero <= dbz_nxt;
        end
    end

    // Next-state, datapath update and ALU drive.
    always_comb begin
        state_nxt     = state;
        rem_nxt       = rem;
        quo_nxt       = quo;
        dvs_nxt       = dvs;
        cnt_nxt       = cnt;
        zdly_nxt      = zdly;
        quotient_nxt  = quotient;
        remainder_nxt = remainder;
        dbz_nxt       = div_by_zero;
        alu_src1      = '0;
        alu_src2      = '0;
        alu_funct     = NOP_FUNCT;

        case (state)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        rem_nxt   = '0;
                        quo_nxt   = dividend;
                        dvs_nxt   = divisor;
                        cnt_nxt   = '0;
                        dbz_nxt   = 1'b0;
                        state_nxt = RUN;
                    end else begin
                        quotient_nxt  = '1;
                        remainder_nxt = dividend;
                        dbz_nxt       = 1'b1;
                        // One extra cycle keeps start-to-done timing fixed.
                        zdly_nxt      = 1'b1;
                        state_nxt     = DONE;
                    end
                end
            end
            RUN: begin
                alu_src1  = shifted;
                alu_src2  = dvs;
                alu_funct = SUB_FUNCT;
                if (sub_ok) begin
                    rem_nxt = alu_result;
                    quo_nxt = {quo[DW-2:0], 1'b1};
                end else begin
                    rem_nxt = shifted;
                    quo_nxt = {quo[DW-2:0], 1'b0};
                end
                cnt_nxt = cnt + CW'(1);
                if (cnt == LAST_ITER) begin
                    quotient_nxt  = quo_nxt;
                    remainder_nxt = rem_nxt;
                    dbz_nxt       = 1'b0;
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                if (zdly) begin
                    zdly_nxt = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status strobes decoded from registered state only.
    assign busy = (state == RUN);
    assign done = (state == DONE) && !zdly;

endmodule

// File: tb/tb_divider_controller.sv
`timescale 1ns/1ps
// Scoreboard bench for divider_controller with a behavioural ALU and model.
module tb_divider_controller;

    localparam logic [5:0] SUB_F = 6'b001010;
    localparam logic [5:0] NOP_F = 6'b000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic [5:0]  alu_funct;
    logic        alu_carry;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    divider_controller #(.SUB_FUNCT(SUB_F), .NOP_FUNCT(NOP_F)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_funct(alu_funct),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Shared ALU: subtract reports borrow on carry, anything else yields zero.
    always_comb begin
        logic [32:0] diff;
        diff = {1'b0, alu_src1} - {1'b0, alu_src2};
        if (alu_funct == SUB_F) begin
            alu_result = diff[31:0];
            alu_carry  = diff[32];
        end else begin
            alu_result = '0;
            alu_carry  = 1'b0;
        end
    end

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          cyc0;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                chk("latency", 32'(cyc - e.cyc0), 32'(e.lat));
                chk("busy_with_done", 32'(busy), 32'd0);
            end
        end
    end

    // Issue one division; optionally fire a stray start mid-run.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit stray);
        exp_t e;
        bit   seen;
        if (b == 0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1; e.lat = 2;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = 33;
        end
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        e.cyc0 = cyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        if (stray && b != 0) begin
            repeat (9) @(negedge clk);
            start = 1'b1; dividend = $urandom; divisor = $urandom | 32'd1;
            @(negedge clk);
            start = 1'b0;
        end
        seen = done;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) begin
            checks++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles (a=%0h b=%0h)", a, b);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #12;
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
        chk("rst_funct", 32'(alu_funct), 32'(NOP_F));
        @(negedge clk);
        rst = 1'b1;

        run_div(32'd100, 32'd7, 1'b0);
        run_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
        run_div(32'd5, 32'd9, 1'b0);
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0);
        run_div(32'd1234, 32'd0, 1'b0);
        run_div(32'd1000, 32'd3, 1'b1);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // Abort mid-run with reset; no done may follow.
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_quotient", quotient, 32'd0);
        chk("abort_remainder", remainder, 32'd0);
        chk("abort_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
        chk("abort_funct", 32'(alu_funct), 32'(NOP_F));
        chk("abort_src1", alu_src1, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        run_div(32'd100, 32'd7, 1'b0);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(1, 15));
                1: b = $urandom;
                2: b = a >> $urandom_range(0, 31);
                default: b = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 65535));
            endcase
            run_div(a, b, i[2]);
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL leftover: got %0d pending results expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
